// File: rtl/daq_packetizer_multi.sv
// ----------------------------------------------------------------------------
// daq_packetizer_multi
//
// Runs one acquisition of a bank of AD7606 chips per trigger. It pulses
// CONVST, waits for BUSY to rise and fall, reads every channel of every chip
// over the shared parallel bus, and streams the result as one framed packet:
//    PREAMBLE, packet counter, ADC_COUNT*CH_PER_ADC samples, [checksum]
//
// Ports
//    clk_i, reset_ni          single clock, asynchronous active-low reset
//    en_i, trig_i             trigger enable / single-cycle trigger request
//    convst_o, busy_i         AD7606 conversion start / bank BUSY (async)
//    frstdata_i               FRSTDATA of the selected chip
//    cs_no, rd_no, db_i       per-chip select, shared RD strobe, data bus
//    m_data_o/valid/ready/last  output stream, single-entry register
//    pkt_active_o             trigger accept .. last word handed off
//    err_timeout_o, err_frst_o, overrun_o   one-cycle status pulses
// ----------------------------------------------------------------------------
module daq_packetizer_multi #(
   parameter int          ADC_COUNT    = 8,
   parameter int          CH_PER_ADC   = 8,
   parameter int          RD_LOW_CYC   = 4,
   parameter int          RD_HIGH_CYC  = 3,
   parameter int          CONV_LOW_CYC = 5,
   parameter int          BUSY_TIMEOUT = 1000,
   parameter logic [15:0] PREAMBLE     = 16'hAAAA,
   parameter int          CHECKSUM_EN  = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 en_i,
   input  logic                 trig_i,
   output logic                 convst_o,
   input  logic                 busy_i,
   input  logic                 frstdata_i,
   output logic [ADC_COUNT-1:0] cs_no,
   output logic                 rd_no,
   input  logic [15:0]          db_i,
   output logic [15:0]          m_data_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic                 m_last_o,
   output logic                 pkt_active_o,
   output logic                 err_timeout_o,
   output logic                 err_frst_o,
   output logic                 overrun_o
);

   localparam int CHIP_W = (ADC_COUNT  > 1) ? $clog2(ADC_COUNT)  : 1;
   localparam int CH_W   = (CH_PER_ADC > 1) ? $clog2(CH_PER_ADC) : 1;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CONV      = 4'd1,
      S_WAIT_HI   = 4'd2,
      S_WAIT_LO   = 4'd3,
      S_HDR_PRE   = 4'd4,
      S_HDR_CNT   = 4'd5,
      S_RD_LOW    = 4'd6,
      S_RD_HIGH   = 4'd7,
      S_TRAILER   = 4'd8,
      S_DONE      = 4'd9
   } state_t;

   // Running checksum: plain 16-bit modular sum of the sample words.
   function automatic logic [15:0] f_csum_add(input logic [15:0] a, input logic [15:0] b);
      return a + b;
   endfunction

   state_t                r_state, w_state_nxt;
   logic                  r_busy_meta, r_busy_sync;
   logic [31:0]           r_cnt, w_cnt_nxt;
   logic [CHIP_W-1:0]     r_chip, w_chip_nxt;
   logic [CH_W-1:0]       r_ch, w_ch_nxt;
   logic [15:0]           r_pkt_cnt, w_pkt_cnt_nxt;
   logic [15:0]           r_csum, w_csum_nxt;
   logic [15:0]           r_data, w_data_nxt;
   logic                  r_valid, w_valid_nxt;
   logic                  r_last, w_last_nxt;
   logic                  r_convst, w_convst_nxt;
   logic                  r_rd_n, w_rd_n_nxt;
   logic [ADC_COUNT-1:0]  r_cs_n, w_cs_n_nxt;
   logic                  r_pkt_active, w_pkt_active_nxt;
   logic                  r_err_timeout, w_err_timeout_nxt;
   logic                  r_err_frst, w_err_frst_nxt;
   logic                  r_overrun, w_overrun_nxt;

   logic                  w_pop;
   logic                  w_space;
   logic                  w_last_chip;
   logic                  w_last_ch;
   logic [CHIP_W-1:0]     w_chip_inc;

   // Handshake and read-position helpers.
   always_comb begin
      w_pop       = r_valid & m_ready_i;
      // The output register can accept a load this cycle if empty or being popped.
      w_space     = ~r_valid | m_ready_i;
      w_last_chip = (r_chip == CHIP_W'(ADC_COUNT - 1));
      w_last_ch   = (r_ch == CH_W'(CH_PER_ADC - 1));
      w_chip_inc  = r_chip + CHIP_W'(1);
   end

   // Next-state and next-output logic for the acquisition sequencer.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_chip_nxt        = r_chip;
      w_ch_nxt          = r_ch;
      w_csum_nxt        = r_csum;
      w_data_nxt        = r_data;
      w_valid_nxt       = w_pop ? 1'b0 : r_valid;
      w_last_nxt        = w_pop ? 1'b0 : r_last;
      w_convst_nxt      = r_convst;
      w_rd_n_nxt        = r_rd_n;
      w_cs_n_nxt        = r_cs_n;
      w_pkt_active_nxt  = r_pkt_active;
      w_err_timeout_nxt = 1'b0;
      w_err_frst_nxt    = 1'b0;
      // Any trigger that does not start a packet is reported and dropped.
      w_overrun_nxt     = trig_i & ~((r_state == S_IDLE) & en_i);
      w_pkt_cnt_nxt     = (w_pop & r_last) ? (r_pkt_cnt + 16'd1) : r_pkt_cnt;

      case (r_state)
         S_IDLE: begin
            if (trig_i & en_i) begin
               w_state_nxt      = S_CONV;
               w_convst_nxt     = 1'b0;
               w_cnt_nxt        = 32'd0;
               w_pkt_active_nxt = 1'b1;
               w_csum_nxt       = 16'd0;
               w_chip_nxt       = '0;
               w_ch_nxt         = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_CONV: begin
            if (r_cnt == 32'(CONV_LOW_CYC - 1)) begin
               w_convst_nxt = 1'b1;
               w_cnt_nxt    = 32'd0;
               w_state_nxt  = S_WAIT_HI;
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
            end
         end

         S_WAIT_HI: begin
            if (r_busy_sync) begin
               w_state_nxt = S_WAIT_LO;
               w_cnt_nxt   = 32'd0;
            end else if (r_cnt == 32'(BUSY_TIMEOUT - 1)) begin
               // Abandon the acquisition: nothing is emitted, counter untouched.
               w_err_timeout_nxt = 1'b1;
               w_pkt_active_nxt  = 1'b0;
               w_state_nxt       = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
            end
         end

         S_WAIT_LO: begin
            if (!r_busy_sync) begin
               w_state_nxt = S_HDR_PRE;
            end else begin
               w_state_nxt = S_WAIT_LO;
            end
         end

         S_HDR_PRE: begin
            if (w_space) begin
               w_data_nxt  = PREAMBLE;
               w_valid_nxt = 1'b1;
               w_last_nxt  = 1'b0;
               w_state_nxt = S_HDR_CNT;
            end else begin
               w_state_nxt = S_HDR_PRE;
            end
         end

         S_HDR_CNT: begin
            if (w_space) begin
               w_data_nxt    = r_pkt_cnt;
               w_valid_nxt   = 1'b1;
               w_last_nxt    = 1'b0;
               w_cs_n_nxt    = {ADC_COUNT{1'b1}};
               w_cs_n_nxt[0] = 1'b0;
               // Enter the gap phase already satisfied so the first read only
               // waits for the output register to drain.
               w_cnt_nxt     = 32'(RD_HIGH_CYC - 1);
               w_state_nxt   = S_RD_HIGH;
            end else begin
               w_state_nxt = S_HDR_CNT;
            end
         end

         S_RD_HIGH: begin
            if (r_cnt >= 32'(RD_HIGH_CYC - 1)) begin
               // Start a read only if the register is free now; nothing else
               // loads it during RD_LOW, so it is still free at capture.
               if (w_space) begin
                  w_rd_n_nxt  = 1'b0;
                  w_cnt_nxt   = 32'd0;
                  w_state_nxt = S_RD_LOW;
               end else begin
                  w_state_nxt = S_RD_HIGH;
               end
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
            end
         end

         S_RD_LOW: begin
            if (r_cnt == 32'(RD_LOW_CYC - 1)) begin
               w_rd_n_nxt     = 1'b1;
               w_data_nxt     = db_i;
               w_valid_nxt    = 1'b1;
               w_csum_nxt     = f_csum_add(r_csum, db_i);
               w_err_frst_nxt = (frstdata_i != (r_ch == CH_W'(0)));
               w_cnt_nxt      = 32'd0;
               if (w_last_chip & w_last_ch) begin
                  w_cs_n_nxt = {ADC_COUNT{1'b1}};
                  w_last_nxt = (CHECKSUM_EN == 0);
                  if (CHECKSUM_EN != 0) begin
                     w_state_nxt = S_TRAILER;
                  end else begin
                     w_state_nxt = S_DONE;
                  end
               end else begin
                  w_last_nxt  = 1'b0;
                  w_state_nxt = S_RD_HIGH;
                  if (w_last_ch) begin
                     w_ch_nxt               = '0;
                     w_chip_nxt             = w_chip_inc;
                     w_cs_n_nxt             = {ADC_COUNT{1'b1}};
                     w_cs_n_nxt[w_chip_inc] = 1'b0;
                  end else begin
                     w_ch_nxt = r_ch + CH_W'(1);
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
            end
         end

         S_TRAILER: begin
            if (w_space) begin
               w_data_nxt  = r_csum;
               w_valid_nxt = 1'b1;
               w_last_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_TRAILER;
            end
         end

         S_DONE: begin
            // Packet stays active until the final word leaves the register.
            if (w_pop & r_last) begin
               w_pkt_active_nxt = 1'b0;
               w_state_nxt      = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end

         default: begin
            w_state_nxt      = S_IDLE;
            w_convst_nxt     = 1'b1;
            w_rd_n_nxt       = 1'b1;
            w_cs_n_nxt       = {ADC_COUNT{1'b1}};
            w_pkt_active_nxt = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; BUSY enters through a 2-flop synchroniser.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state       <= S_IDLE;
         r_busy_meta   <= 1'b0;
         r_busy_sync   <= 1'b0;
         r_cnt         <= 32'd0;
         r_chip        <= '0;
         r_ch          <= '0;
         r_pkt_cnt     <= 16'd0;
         r_csum        <= 16'd0;
         r_data        <= 16'd0;
         r_valid       <= 1'b0;
         r_last        <= 1'b0;
         r_convst      <= 1'b1;
         r_rd_n        <= 1'b1;
         r_cs_n        <= {ADC_COUNT{1'b1}};
         r_pkt_active  <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_frst    <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_busy_meta   <= busy_i;
         r_busy_sync   <= r_busy_meta;
         r_cnt         <= w_cnt_nxt;
         r_chip        <= w_chip_nxt;
         r_ch          <= w_ch_nxt;
         r_pkt_cnt     <= w_pkt_cnt_nxt;
         r_csum        <= w_csum_nxt;
         r_data        <= w_data_nxt;
         r_valid       <= w_valid_nxt;
         r_last        <= w_last_nxt;
         r_convst      <= w_convst_nxt;
         r_rd_n        <= w_rd_n_nxt;
         r_cs_n        <= w_cs_n_nxt;
         r_pkt_active  <= w_pkt_active_nxt;
         r_err_timeout <= w_err_timeout_nxt;
         r_err_frst    <= w_err_frst_nxt;
         r_overrun     <= w_overrun_nxt;
      end
   end

   // Output ports are driven straight from registers.
   always_comb begin
      convst_o      = r_convst;
      cs_no         = r_cs_n;
      rd_no         = r_rd_n;
      m_data_o      = r_data;
      m_valid_o     = r_valid;
      m_last_o      = r_last;
      pkt_active_o  = r_pkt_active;
      err_timeout_o = r_err_timeout;
      err_frst_o    = r_err_frst;
      overrun_o     = r_overrun;
   end

endmodule

// File: tb/tb_daq_packetizer_multi.sv
module tb_daq_packetizer_multi;

   localparam int NADC    = 2;
   localparam int NCH     = 4;
   localparam int TMO     = 40;
   localparam int CONVLOW = 5;
   localparam int PKT_LEN = 2 + NADC * NCH + 1;

   logic              clk = 1'b0;
   logic              reset_ni, en_i, trig_i, busy_i, frstdata_i, m_ready_i;
   logic              convst_o, rd_no, m_valid_o, m_last_o, pkt_active_o;
   logic              err_timeout_o, err_frst_o, overrun_o;
   logic [NADC-1:0]   cs_no;
   logic [15:0]       db_i, m_data_o;

   daq_packetizer_multi #(
      .ADC_COUNT(NADC), .CH_PER_ADC(NCH), .RD_LOW_CYC(4), .RD_HIGH_CYC(3),
      .CONV_LOW_CYC(CONVLOW), .BUSY_TIMEOUT(TMO), .PREAMBLE(16'hAAAA), .CHECKSUM_EN(1)
   ) dut (
      .clk_i(clk), .reset_ni(reset_ni), .en_i(en_i), .trig_i(trig_i),
      .convst_o(convst_o), .busy_i(busy_i), .frstdata_i(frstdata_i),
      .cs_no(cs_no), .rd_no(rd_no), .db_i(db_i),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .m_last_o(m_last_o), .pkt_active_o(pkt_active_o),
      .err_timeout_o(err_timeout_o), .err_frst_o(err_frst_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic        last;
   } vec_t;

   vec_t tbl [PKT_LEN];

   int vec_cnt = 0;
   int miscomp = 0;

   // bench model / monitor state
   int          cyc = 0;
   int          m_chip = -1;
   int          m_ch = 0;
   logic        prev_rd = 1'b1;
   logic        prev_conv = 1'b1;
   int          busy_cnt = 0;
   bit          busy_en = 1'b1;
   bit          force_frst = 1'b0;
   int          conv_rise_cyc = 0;
   int          conv_low_cnt = 0;
   int          to_cnt = 0;
   int          to_cyc = 0;
   int          overrun_cnt = 0;
   int          frst_cnt = 0;
   int          valid_cyc = 0;
   int          last_cnt = 0;
   logic [15:0] q_data[$];
   logic        q_last[$];
   int          rd_fall_q[$];

   // ADC bank model, BUSY model and output monitor, all on the falling edge
   always @(negedge clk) begin
      int cur;
      cyc++;
      if (cs_no == 2'b11) begin
         m_chip = -1;
         m_ch   = 0;
      end else begin
         cur = cs_no[0] ? 1 : 0;
         if (cur != m_chip) m_ch = 0;
         else if (!prev_rd && rd_no) m_ch++;
         m_chip = cur;
      end
      if (prev_rd && !rd_no) rd_fall_q.push_back(cyc);
      prev_rd = rd_no;
      db_i = (m_chip < 0) ? 16'h0000 : 16'(256 * m_chip + m_ch);
      frstdata_i = (m_ch == 0) && !(force_frst && m_chip == 1);

      if (!prev_conv && convst_o) begin
         conv_rise_cyc = cyc;
         if (busy_en) busy_cnt = 12;
      end
      prev_conv = convst_o;
      busy_i = (busy_cnt > 0) && (busy_cnt <= 10);
      if (busy_cnt > 0) busy_cnt--;

      if (!convst_o) conv_low_cnt++;
      if (err_timeout_o) begin to_cnt++; to_cyc = cyc; end
      if (overrun_o) overrun_cnt++;
      if (err_frst_o) frst_cnt++;
      if (m_valid_o) valid_cyc++;
      if (m_valid_o && m_ready_i) begin
         q_data.push_back(m_data_o);
         q_last.push_back(m_last_o);
         if (m_last_o) last_cnt++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscomp++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse_trig();
      @(posedge clk); #1 trig_i = 1'b1;
      @(posedge clk); #1 trig_i = 1'b0;
   endtask

   task automatic clear_mon();
      q_data.delete(); q_last.delete(); rd_fall_q.delete(); last_cnt = 0;
   endtask

   task automatic wait_last(input int n, input int maxc, input string nm);
      int k = 0;
      while (last_cnt < n && k < maxc) begin @(posedge clk); k++; end
      check(nm, 32'(last_cnt >= n), 32'd1);
   endtask

   task automatic wait_words(input int n, input int maxc, input string nm);
      int k = 0;
      while (q_data.size() < n && k < maxc) begin @(posedge clk); k++; end
      check(nm, 32'(q_data.size() >= n), 32'd1);
   endtask

   task automatic check_packet(input string tag, input logic [15:0] exp_cnt);
      logic [15:0] e;
      check({tag, "_len"}, 32'(q_data.size()), 32'(PKT_LEN));
      for (int i = 0; i < PKT_LEN; i++) begin
         if (i < q_data.size()) begin
            e = (i == 1) ? exp_cnt : tbl[i].data;
            check({tag, "_", tbl[i].name}, {16'd0, q_data[i]}, {16'd0, e});
            check({tag, "_", tbl[i].name, "_last"}, {31'd0, q_last[i]}, {31'd0, tbl[i].last});
         end
      end
   endtask

   initial begin
      int t0, o0, c0, f0;
      // expected packet: preamble, counter (patched per packet), samples, checksum
      tbl[0] = '{"pre", 16'hAAAA, 1'b0};
      tbl[1] = '{"cnt", 16'h0000, 1'b0};
      tbl[2] = '{"c0s0", 16'h0000, 1'b0};
      tbl[3] = '{"c0s1", 16'h0001, 1'b0};
      tbl[4] = '{"c0s2", 16'h0002, 1'b0};
      tbl[5] = '{"c0s3", 16'h0003, 1'b0};
      tbl[6] = '{"c1s0", 16'h0100, 1'b0};
      tbl[7] = '{"c1s1", 16'h0101, 1'b0};
      tbl[8] = '{"c1s2", 16'h0102, 1'b0};
      tbl[9] = '{"c1s3", 16'h0103, 1'b0};
      // 0+1+2+3 + 0x100+0x101+0x102+0x103 = 0x040C
      tbl[10] = '{"csum", 16'h040C, 1'b1};

      reset_ni = 1'b0; en_i = 1'b1; trig_i = 1'b0; m_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_convst", {31'd0, convst_o}, 32'd1);
      check("rst_rd", {31'd0, rd_no}, 32'd1);
      check("rst_cs", {30'd0, cs_no}, 32'd3);
      check("rst_valid", {31'd0, m_valid_o}, 32'd0);
      check("rst_last", {31'd0, m_last_o}, 32'd0);
      check("rst_data", {16'd0, m_data_o}, 32'd0);
      check("rst_active", {31'd0, pkt_active_o}, 32'd0);
      check("rst_errs", {29'd0, err_timeout_o, err_frst_o, overrun_o}, 32'd0);
      reset_ni = 1'b1;
      repeat (2) @(posedge clk);

      // BUSY never rises: timeout pulse, nothing emitted
      busy_en = 1'b0; t0 = to_cnt;
      pulse_trig();
      check("conv_low_first", {31'd0, convst_o}, 32'd0);
      check("active_on_trig", {31'd0, pkt_active_o}, 32'd1);
      repeat (CONVLOW - 1) @(posedge clk);
      #1 check("conv_low_last", {31'd0, convst_o}, 32'd0);
      @(posedge clk);
      #1 check("conv_high", {31'd0, convst_o}, 32'd1);
      for (int k = 0; k < 200 && to_cnt == t0; k++) @(posedge clk);
      check("timeout_pulses", 32'(to_cnt - t0), 32'd1);
      check("timeout_delay", 32'(to_cyc - conv_rise_cyc), 32'(TMO));
      check("timeout_no_valid", 32'(valid_cyc), 32'd0);
      busy_en = 1'b1;
      repeat (5) @(posedge clk);

      // Normal packet, counter still 0000 after the timeout
      clear_mon();
      pulse_trig();
      wait_last(1, 500, "pktA_done");
      check_packet("pktA", 16'h0000);
      if (rd_fall_q.size() >= 8) begin
         check("rd_period", 32'(rd_fall_q[2] - rd_fall_q[1]), 32'd7);
         check("rd_period_xchip", 32'(rd_fall_q[4] - rd_fall_q[3]), 32'd7);
      end else begin
         check("rd_count", 32'(rd_fall_q.size()), 32'd8);
      end
      repeat (3) @(posedge clk);
      #1 check("active_after", {31'd0, pkt_active_o}, 32'd0);

      // 50-cycle back-pressure in the middle of the reads
      clear_mon();
      pulse_trig();
      wait_words(4, 500, "pktB_reach4");
      @(posedge clk); #1 m_ready_i = 1'b0;
      repeat (10) @(posedge clk);
      f0 = rd_fall_q.size();
      repeat (40) @(posedge clk);
      #1;
      check("stall_no_rd", 32'(rd_fall_q.size()), 32'(f0));
      check("stall_rd_high", {31'd0, rd_no}, 32'd1);
      check("stall_valid", {31'd0, m_valid_o}, 32'd1);
      m_ready_i = 1'b1;
      wait_last(1, 500, "pktB_done");
      check_packet("pktB", 16'h0001);

      // Trigger while waiting for BUSY low: one overrun, one packet
      clear_mon(); o0 = overrun_cnt;
      pulse_trig();
      for (int k = 0; k < 100 && !busy_i; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      pulse_trig();
      wait_last(1, 500, "pktC_done");
      repeat (100) @(posedge clk);
      check("wbl_overrun", 32'(overrun_cnt - o0), 32'd1);
      check("wbl_one_pkt", 32'(last_cnt), 32'd1);
      check_packet("pktC", 16'h0002);

      // en_i low: trigger rejected, no CONVST
      en_i = 1'b0; o0 = overrun_cnt; c0 = conv_low_cnt;
      pulse_trig();
      repeat (20) @(posedge clk);
      check("en_overrun", 32'(overrun_cnt - o0), 32'd1);
      check("en_no_conv", 32'(conv_low_cnt - c0), 32'd0);
      en_i = 1'b1;

      // FRSTDATA wrong on chip 1 channel 0
      clear_mon(); force_frst = 1'b1; f0 = frst_cnt;
      pulse_trig();
      wait_last(1, 500, "pktD_done");
      check("frst_pulse", 32'(frst_cnt - f0), 32'd1);
      check_packet("pktD", 16'h0003);
      force_frst = 1'b0;
      repeat (5) @(posedge clk);

      // Reset in the middle of the reads
      clear_mon();
      pulse_trig();
      wait_words(3, 500, "pktE_reach3");
      @(posedge clk); #1 reset_ni = 1'b0;
      #1;
      check("mid_rst_cs", {30'd0, cs_no}, 32'd3);
      check("mid_rst_rd", {31'd0, rd_no}, 32'd1);
      check("mid_rst_valid", {31'd0, m_valid_o}, 32'd0);
      check("mid_rst_active", {31'd0, pkt_active_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_ni = 1'b1;
      repeat (20) @(posedge clk);
      clear_mon();
      pulse_trig();
      wait_last(1, 500, "pktF_done");
      check_packet("pktF", 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
      $finish;
   end

endmodule
